// File: rtl/sample_feeder_pkg.sv
// rtl/sample_feeder_pkg.sv - shared types and constants for the sample feeder
package sample_feeder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DROP_CNT_W    = 8;

    typedef enum logic {
        IDLE,
        GAP
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with head look-ahead and occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level == (AW + 1)'(DEPTH));
    assign empty    = (level == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level <= level + 1'b1;
            end else if (pop_ok && !push_ok) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sample_feeder.sv
// rtl/sample_feeder.sv - buffers producer samples, drops zeros, emits paced pulses
module sample_feeder
    import sample_feeder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = 4,
    parameter int GAP       = 1,
    parameter bit DROP_ZERO = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     valid_out,
    output logic [WIDTH-1:0]         data_out,
    output logic [DROP_CNT_W-1:0]    drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int GW = ($clog2(GAP + 1) > 0) ? $clog2(GAP + 1) : 1;

    state_t           state;
    logic [GW-1:0]    gap_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;
    logic             accept;
    logic             is_drop;
    logic             fifo_push;
    logic             fifo_pop;

    assign in_ready  = !fifo_full && !reset;
    assign accept    = in_valid && in_ready;
    assign is_drop   = DROP_ZERO && (in_data == '0);
    assign fifo_push = accept && !is_drop;
    assign fifo_pop  = (state == sample_feeder_pkg::IDLE) && !fifo_empty;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (accept && is_drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // The GAP parameter shadows the imported state name, hence the scoped literals.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= sample_feeder_pkg::IDLE;
            gap_cnt   <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            case (state)
                sample_feeder_pkg::IDLE: begin
                    if (!fifo_empty) begin
                        data_out  <= fifo_head;
                        valid_out <= 1'b1;
                        if (GAP > 0) begin
                            state   <= sample_feeder_pkg::GAP;
                            gap_cnt <= GW'(GAP);
                        end
                    end else begin
                        valid_out <= 1'b0;
                    end
                end
                sample_feeder_pkg::GAP: begin
                    valid_out <= 1'b0;
                    gap_cnt   <= gap_cnt - GW'(1);
                    if (gap_cnt == GW'(1)) begin
                        state <= sample_feeder_pkg::IDLE;
                    end
                end
                default: begin
                    state     <= sample_feeder_pkg::IDLE;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_feeder.sv
// tb/tb_sample_feeder.sv - directed self-checking bench for sample_feeder
module tb_sample_feeder;

    // instance 0: GAP=0, instance 1: GAP=1, instance 2: GAP=3
    logic       clk = 1'b0;
    logic       reset     [3];
    logic       in_valid  [3];
    logic [7:0] in_data   [3];
    logic       in_ready  [3];
    logic       valid_out [3];
    logic [7:0] data_out  [3];
    logic [7:0] drop_cnt  [3];
    logic [2:0] level     [3];

    int cyc = 0;
    int total = 0;
    int passed = 0;
    int q_data [3][$];
    int q_cyc  [3][$];
    int maxlvl  [3];
    int b2b_err [3];
    int rdy_err [3];
    bit prev_vo [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sample_feeder #(.WIDTH(8), .DEPTH(4), .GAP(0), .DROP_ZERO(1'b1)) u_dut0 (
        .clk(clk), .reset(reset[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .valid_out(valid_out[0]), .data_out(data_out[0]),
        .drop_cnt(drop_cnt[0]), .level(level[0]));

    sample_feeder #(.WIDTH(8), .DEPTH(4), .GAP(1), .DROP_ZERO(1'b1)) u_dut1 (
        .clk(clk), .reset(reset[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .valid_out(valid_out[1]), .data_out(data_out[1]),
        .drop_cnt(drop_cnt[1]), .level(level[1]));

    sample_feeder #(.WIDTH(8), .DEPTH(4), .GAP(3), .DROP_ZERO(1'b1)) u_dut2 (
        .clk(clk), .reset(reset[2]), .in_valid(in_valid[2]), .in_data(in_data[2]),
        .in_ready(in_ready[2]), .valid_out(valid_out[2]), .data_out(data_out[2]),
        .drop_cnt(drop_cnt[2]), .level(level[2]));

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset[i]) begin
                if (valid_out[i]) begin
                    q_data[i].push_back(int'(data_out[i]));
                    q_cyc[i].push_back(cyc);
                    if (prev_vo[i] && i != 0) b2b_err[i]++;
                end
                if (int'(level[i]) > maxlvl[i]) maxlvl[i] = int'(level[i]);
                if (in_ready[i] != (level[i] != 3'd4)) rdy_err[i]++;
            end
            prev_vo[i] = valid_out[i];
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic push(input int i, input int v, output int acc);
        int n;
        bit rdy;
        in_valid[i] = 1'b1;
        in_data[i]  = 8'(v);
        n = 0;
        do begin
            @(negedge clk);
            rdy = in_ready[i];
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) check("push_timeout", 0, 1);
        acc = cyc;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear(input int i);
        q_data[i].delete();
        q_cyc[i].delete();
        maxlvl[i] = 0;
    endtask

    function automatic int qd(input int i, input int k);
        return (k < q_data[i].size()) ? q_data[i][k] : -1;
    endfunction

    function automatic int qgap(input int i, input int k);
        return (k < q_cyc[i].size()) ? q_cyc[i][k] - q_cyc[i][k-1] : -1;
    endfunction

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int a0;
        int exp_ord [5];
        exp_ord = '{10, 4, 7, 9, 11};

        for (int i = 0; i < 3; i++) begin
            reset[i] = 1'b1; in_valid[i] = 1'b1; in_data[i] = 8'd9;
            maxlvl[i] = 0; b2b_err[i] = 0; rdy_err[i] = 0; prev_vo[i] = 1'b0;
        end

        // reset held with a transfer presented
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready[1]), 0);
        check("rst_valid_out", int'(valid_out[1]), 0);
        check("rst_data_out", int'(data_out[1]), 0);
        check("rst_level", int'(level[1]), 0);
        check("rst_drop_cnt", int'(drop_cnt[1]), 0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) reset[i] = 1'b0;
        @(negedge clk);
        check("rel_level0", int'(level[1]), 0);
        check("rel_in_ready", int'(in_ready[1]), 1);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
        @(negedge clk);
        check("rel_level1", int'(level[1]), 1);
        wait_cycles(10);
        for (int i = 0; i < 3; i++) clear(i);

        // ordered forwarding, GAP=1
        push(1, 10, a0);
        push(1, 4, acc);
        push(1, 7, acc);
        push(1, 9, acc);
        push(1, 11, acc);
        in_valid[1] = 1'b0;
        wait_cycles(16);
        check("ord_count", q_data[1].size(), 5);
        for (int k = 0; k < 5; k++) check($sformatf("ord_data%0d", k), qd(1, k), exp_ord[k]);
        for (int k = 1; k < 5; k++) check($sformatf("ord_spacing%0d", k), qgap(1, k), 2);
        check("ord_first_latency", (q_cyc[1].size() > 0) ? q_cyc[1][0] + 1 - a0 : -1, 2);

        // zero drop
        clear(1);
        push(1, 5, acc);
        push(1, 0, acc);
        push(1, 0, acc);
        push(1, 12, acc);
        in_valid[1] = 1'b0;
        wait_cycles(10);
        check("zero_count", q_data[1].size(), 2);
        check("zero_data0", qd(1, 0), 5);
        check("zero_data1", qd(1, 1), 12);
        check("zero_drop_cnt", int'(drop_cnt[1]), 2);
        check("zero_maxlvl_le2", int'(maxlvl[1] <= 2), 1);

        // full / backpressure, GAP=3
        clear(2);
        for (int v = 1; v <= 8; v++) push(2, v, acc);
        in_valid[2] = 1'b0;
        wait_cycles(45);
        check("full_count", q_data[2].size(), 8);
        for (int k = 0; k < 8; k++) check($sformatf("full_data%0d", k), qd(2, k), k + 1);
        for (int k = 1; k < 8; k++) check($sformatf("full_spacing%0d", k), qgap(2, k), 4);
        check("full_maxlvl", maxlvl[2], 4);

        // back-to-back, GAP=0
        clear(0);
        push(0, 13, acc);
        push(0, 3, acc);
        push(0, 14, acc);
        in_valid[0] = 1'b0;
        wait_cycles(8);
        check("b2b_count", q_data[0].size(), 3);
        check("b2b_data0", qd(0, 0), 13);
        check("b2b_data1", qd(0, 1), 3);
        check("b2b_data2", qd(0, 2), 14);
        check("b2b_spacing1", qgap(0, 1), 1);
        check("b2b_spacing2", qgap(0, 2), 1);
        check("b2b_hold", int'(data_out[0]), 14);

        // reset mid-stream with level=3 in GAP
        clear(2);
        push(2, 0, acc);
        push(2, 21, acc);
        push(2, 22, acc);
        push(2, 23, acc);
        push(2, 24, acc);
        in_valid[2] = 1'b0;
        @(negedge clk);
        check("mid_pre_level", int'(level[2]), 3);
        check("mid_pre_valid", int'(valid_out[2]), 0);
        check("mid_pre_drop", int'(drop_cnt[2]), 1);
        reset[2] = 1'b1;
        @(posedge clk); #1;
        reset[2] = 1'b0;
        clear(2);
        wait_cycles(10);
        check("mid_no_output", q_data[2].size(), 0);
        check("mid_drop_cnt", int'(drop_cnt[2]), 0);
        check("mid_level", int'(level[2]), 0);
        check("mid_data_out", int'(data_out[2]), 0);
        push(2, 8, a0);
        in_valid[2] = 1'b0;
        wait_cycles(8);
        check("mid_new_count", q_data[2].size(), 1);
        check("mid_new_data", qd(2, 0), 8);
        check("mid_new_latency", (q_cyc[2].size() > 0) ? q_cyc[2][0] + 1 - a0 : -1, 2);

        check("gap1_no_consecutive", b2b_err[1], 0);
        check("gap3_no_consecutive", b2b_err[2], 0);
        check("in_ready_vs_level", rdy_err[0] + rdy_err[1] + rdy_err[2], 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sample_feeder.md
# sample_feeder

Upstream feeder for the second-highest tracker. Accepts 8-bit samples from a producer over a valid/ready handshake, buffers them in a small FIFO and drops zero-valued samples. It presents the survivors on the `valid_out`/`data_out` pair that drives the tracker's `valid_in`/`data_in`, with a fixed programmable idle gap between emitted samples.

## Interface
- `WIDTH`, 8: sample width in bits.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `GAP`, 1: idle cycles forced between consecutive `valid_out` pulses; 0 = back-to-back.
- `DROP_ZERO`, 1: when 1, zero-valued samples are consumed but not forwarded.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer has a sample.
- `in_data`  in  WIDTH  producer sample.
- `in_ready`  out  1  feeder can accept; transfer on `in_valid & in_ready` at a rising edge.
- `valid_out`  out  1  one-cycle pulse per forwarded sample; no backpressure from downstream.
- `data_out`  out  WIDTH  forwarded sample; holds its last value while `valid_out`=0.
- `drop_cnt`  out  8  count of zero samples dropped; saturates at 255.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Reset values: `valid_out`=0, `data_out`=0, `drop_cnt`=0, `level`=0, FIFO empty, state IDLE, gap counter 0.
- `in_ready` = !full && !reset. It is derived from the registered occupancy only. There is no full-FIFO bypass: when full, `in_ready`=0 even if a pop occurs in the same cycle.
- Accepted sample with `in_data`==0 and `DROP_ZERO`=1:
  - not written to the FIFO;
  - `drop_cnt` increments, saturating at 255.
- Any other accepted sample is written at the tail.
- FSM:
  - IDLE: if FIFO not empty, pop the head, register it into `data_out` and set `valid_out`=1 for the next cycle. Next state is GAP when `GAP`>0 (load gap counter with `GAP`), otherwise stay in IDLE.
  - GAP: `valid_out`=0. Decrement the counter each cycle and return to IDLE when it reaches 1.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- Pointers wrap modulo `DEPTH`.
- Ordering: samples are strictly FIFO. A dropped zero does not create a bubble.
- A `reset` asserted mid-operation:
  - discards FIFO contents;
  - aborts GAP;
  - clears all outputs at the next edge.
- A transfer presented in the reset cycle is ignored.

## Timing
- Latency: sample accepted at edge k into an empty FIFO with state IDLE → popped at edge k+1 → `valid_out`=1 in the cycle following edge k+1. The tracker samples it at edge k+2.
- Throughput: at most one output every `GAP`+1 cycles. Input may sustain one per cycle until full.
- `level` and `in_ready` update at the edge after a push or pop.
- `valid_out` is never high for two consecutive cycles when `GAP`≥1.

## Structure
- Shared package `sample_feeder_pkg` holds:
  - state typedef (`IDLE`, `GAP`);
  - default `WIDTH` constant;
  - drop-counter width constant.
- The storage is natural as one sub-module, `sync_fifo`. It is parameterised by `WIDTH`/`DEPTH` and has push, pop, full, empty and level. The FSM, drop filter and gap counter sit in `sample_feeder`.

## Test plan
- Reset behaviour:
  - Stimulus: hold `reset`=1 for 2 cycles with `in_valid`=1 and `in_data`=9.
  - Response: `in_ready`=0, `valid_out`=0, `data_out`=0, `level`=0. After release, `level` goes 0 → 1 only once `in_ready`=1.
- Ordered forwarding:
  - Stimulus: `GAP`=1; push 10, 4, 7, 9, 11 on consecutive cycles.
  - Response: `valid_out` pulses every other cycle carrying 10, 4, 7, 9, 11. The first pulse appears 2 edges after accepting 10.
- Zero drop:
  - Stimulus: push 5, 0, 0, 12.
  - Response: outputs are 5 then 12 only; `drop_cnt`=2; `level` never exceeds 2.
- Full / backpressure:
  - Stimulus: `DEPTH`=4, `GAP`=3; push 1..8 with `in_valid` held high.
  - Response: `in_ready` drops when `level`=4. No sample is lost or duplicated. Outputs are 1..8 spaced 4 cycles apart.
- Back-to-back output:
  - Stimulus: `GAP`=0; push 13, 3, 14.
  - Response: `valid_out` high for 3 consecutive cycles with 13, 3, 14. `data_out` holds 14 afterwards.
- Reset mid-stream:
  - Stimulus: with `level`=3 and state GAP, pulse `reset` for 1 cycle.
  - Response: no further `valid_out` pulse from the old contents; `drop_cnt`=0; the next push of 8 emits 8 with nominal latency.
